// File: rtl/reg_bus_arb2_if.sv
// Requester-side and target-side signals of the two-port reg_* arbiter.
// slave = arbiter view, master = requesters plus register target.
interface reg_bus_arb2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [1:0]              rq_valid;
    logic [1:0]              rq_we;
    logic [2*ADDR_WIDTH-1:0] rq_addr;
    logic [2*DATA_WIDTH-1:0] rq_wdata;
    logic [2*STRB_WIDTH-1:0] rq_wstrb;
    logic [1:0]              rq_done;
    logic [DATA_WIDTH-1:0]   rq_rdata;
    logic                    rq_okay;

    logic [ADDR_WIDTH-1:0]   reg_rd_addr;
    logic                    reg_rd_en;
    logic [DATA_WIDTH-1:0]   reg_rd_data;
    logic                    reg_rd_okay;
    logic [ADDR_WIDTH-1:0]   reg_wr_addr;
    logic [DATA_WIDTH-1:0]   reg_wr_data;
    logic [STRB_WIDTH-1:0]   reg_wr_strb;
    logic                    reg_wr_en;
    logic                    reg_wr_okay;

    modport slave (
        input  rq_valid, rq_we, rq_addr, rq_wdata, rq_wstrb,
        output rq_done, rq_rdata, rq_okay,
        output reg_rd_addr, reg_rd_en,
        input  reg_rd_data, reg_rd_okay,
        output reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
        input  reg_wr_okay
    );

    modport master (
        output rq_valid, rq_we, rq_addr, rq_wdata, rq_wstrb,
        input  rq_done, rq_rdata, rq_okay,
        input  reg_rd_addr, reg_rd_en,
        output reg_rd_data, reg_rd_okay,
        input  reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
        output reg_wr_okay
    );
endinterface

// File: rtl/reg_bus_arb2.sv
// Round-robin arbiter letting two requesters share one reg_* target port.
// One transaction in flight; the target answers TGT_LAT cycles after en.
module reg_bus_arb2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TGT_LAT    = 1
) (
    input logic           clk,
    input logic           rst,
    reg_bus_arb2_if.slave bus
);
    localparam int CW = (TGT_LAT > 1) ? $clog2(TGT_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    logic                  grant;
    logic                  last_grant;
    logic                  we_q;
    logic [CW-1:0]         cnt;

    logic [1:0]            done_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  okay_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [STRB_WIDTH-1:0] wr_strb_q;
    logic                  wr_en_q;

    logic                  pick;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_wstrb;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        pick = bus.rq_valid[1];
        if (&bus.rq_valid) begin
            pick = ~last_grant;
        end
    end

    always_comb begin
        sel_we    = bus.rq_we[0];
        sel_addr  = bus.rq_addr[ADDR_WIDTH-1:0];
        sel_wdata = bus.rq_wdata[DATA_WIDTH-1:0];
        sel_wstrb = bus.rq_wstrb[STRB_WIDTH-1:0];
        if (pick) begin
            sel_we    = bus.rq_we[1];
            sel_addr  = bus.rq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
            sel_wdata = bus.rq_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
            sel_wstrb = bus.rq_wstrb[2*STRB_WIDTH-1:STRB_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            cnt        <= '0;
            done_q     <= 2'b00;
            rdata_q    <= '0;
            okay_q     <= 1'b0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.rq_valid) begin
                        grant <= pick;
                        we_q  <= sel_we;
                        if (sel_we) begin
                            wr_addr_q <= sel_addr;
                            wr_data_q <= sel_wdata;
                            wr_strb_q <= sel_wstrb;
                            wr_en_q   <= 1'b1;
                        end else begin
                            rd_addr_q <= sel_addr;
                            rd_en_q   <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    cnt     <= CW'(TGT_LAT - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        // A write completion reports zero read data.
                        if (we_q) begin
                            rdata_q <= '0;
                            okay_q  <= bus.reg_wr_okay;
                        end else begin
                            rdata_q <= bus.reg_rd_data;
                            okay_q  <= bus.reg_rd_okay;
                        end
                        last_grant <= grant;
                        done_q     <= grant ? 2'b10 : 2'b01;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    done_q <= 2'b00;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rq_done     = done_q;
    assign bus.rq_rdata    = rdata_q;
    assign bus.rq_okay     = okay_q;
    assign bus.reg_rd_addr = rd_addr_q;
    assign bus.reg_rd_en   = rd_en_q;
    assign bus.reg_wr_addr = wr_addr_q;
    assign bus.reg_wr_data = wr_data_q;
    assign bus.reg_wr_strb = wr_strb_q;
    assign bus.reg_wr_en   = wr_en_q;
endmodule

// File: tb/tb_reg_bus_arb2.sv
// Bench for reg_bus_arb2: TGT_LAT=1 and TGT_LAT=3 instances, each with a
// one-register target at 0x1000 that reads back data+1.
module tb_reg_bus_arb2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bus_arb2_if b1 ();
    reg_bus_arb2_if b3 ();

    reg_bus_arb2 #(.TGT_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    reg_bus_arb2 #(.TGT_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    typedef struct packed {
        logic [1:0]  done;
        logic [31:0] rdata;
        logic        okay;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    // TGT_LAT=1 target
    logic [31:0] reg1 = 32'h0;
    int rd_en1 = 0;
    int wr_en1 = 0;
    always @(posedge clk) begin
        if (b1.reg_wr_en) begin
            wr_en1 <= wr_en1 + 1;
            b1.reg_wr_okay <= (b1.reg_wr_addr == 32'h1000);
            if (b1.reg_wr_addr == 32'h1000)
                reg1 <= (reg1 & ~mask(b1.reg_wr_strb)) |
                        (b1.reg_wr_data & mask(b1.reg_wr_strb));
        end
        if (b1.reg_rd_en) begin
            rd_en1 <= rd_en1 + 1;
            b1.reg_rd_okay <= (b1.reg_rd_addr == 32'h1000);
            b1.reg_rd_data <= (b1.reg_rd_addr == 32'h1000) ? reg1 + 1 : 32'h0;
        end
    end

    // TGT_LAT=3 target: answer travels through two extra stages
    logic [31:0] reg3 = 32'h0;
    logic [31:0] d3a = 32'h0, d3b = 32'h0;
    logic        o3a = 1'b0, o3b = 1'b0, w3a = 1'b0, w3b = 1'b0;
    int rd_en3 = 0;
    int wr_en3 = 0;
    always @(posedge clk) begin
        if (b3.reg_wr_en) begin
            wr_en3 <= wr_en3 + 1;
            w3a <= (b3.reg_wr_addr == 32'h1000);
            if (b3.reg_wr_addr == 32'h1000)
                reg3 <= (reg3 & ~mask(b3.reg_wr_strb)) |
                        (b3.reg_wr_data & mask(b3.reg_wr_strb));
        end
        if (b3.reg_rd_en) begin
            rd_en3 <= rd_en3 + 1;
            o3a <= (b3.reg_rd_addr == 32'h1000);
            d3a <= (b3.reg_rd_addr == 32'h1000) ? reg3 + 1 : 32'h0;
        end
        d3b <= d3a;
        o3b <= o3a;
        w3b <= w3a;
        b3.reg_rd_data <= d3b;
        b3.reg_rd_okay <= o3b;
        b3.reg_wr_okay <= w3b;
    end

    always @(negedge clk) begin
        if (!rst && b1.rq_done != 2'b00) begin
            if (q1.size() == 0) begin
                check("done1_unexpected", 64'(b1.rq_done), 64'h0);
            end else begin
                check("done1_port", 64'(b1.rq_done), 64'(q1[0].done));
                check("done1_rdata", 64'(b1.rq_rdata), 64'(q1[0].rdata));
                check("done1_okay", 64'(b1.rq_okay), 64'(q1[0].okay));
                void'(q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b3.rq_done != 2'b00) begin
            if (q3.size() == 0) begin
                check("done3_unexpected", 64'(b3.rq_done), 64'h0);
            end else begin
                check("done3_port", 64'(b3.rq_done), 64'(q3[0].done));
                check("done3_rdata", 64'(b3.rq_rdata), 64'(q3[0].rdata));
                check("done3_okay", 64'(b3.rq_okay), 64'(q3[0].okay));
                void'(q3.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // n commands on port p with valid held; lat = cycles to first done
    task automatic run(input int p, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input int n, output int lat);
        int t0;
        bit hit;
        lat = -1;
        b1.rq_we[p] = we;
        b1.rq_addr[p*32 +: 32] = a;
        b1.rq_wdata[p*32 +: 32] = d;
        b1.rq_wstrb[p*4 +: 4] = 4'hF;
        b1.rq_valid[p] = 1'b1;
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            hit = 1'b0;
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                if (b1.rq_done[p]) begin
                    hit = 1'b1;
                    break;
                end
            end
            if (!hit) check("done_timeout", 64'h0, 64'h1);
            if (k == 0) lat = cyc - t0;
        end
        b1.rq_valid[p] = 1'b0;
    endtask

    int lat, l0, l1, e0, t0;
    bit hit;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.rq_valid = '0; b1.rq_we = '0; b1.rq_addr = '0;
        b1.rq_wdata = '0; b1.rq_wstrb = '0;
        b3.rq_valid = '0; b3.rq_we = '0; b3.rq_addr = '0;
        b3.rq_wdata = '0; b3.rq_wstrb = '0;
        idle(2);
        check("rst_ctl1", 64'({b1.rq_done, b1.rq_okay, b1.reg_rd_en, b1.reg_wr_en}), 64'h0);
        check("rst_rdata1", 64'(b1.rq_rdata), 64'h0);
        check("rst_bus1", 64'(b1.reg_rd_addr | b1.reg_wr_addr | b1.reg_wr_data), 64'h0);
        check("rst_ctl3", 64'({b3.rq_done, b3.rq_okay, b3.reg_rd_en, b3.reg_wr_en}), 64'h0);
        rst = 1'b0;
        idle(2);

        // P0 write then read of the target register
        q1.push_back('{2'b01, 32'h0, 1'b1});
        run(0, 1'b1, 32'h1000, 32'h41, 1, lat);
        check("t1_wr_lat", 64'(lat), 64'd3);
        idle(1);
        q1.push_back('{2'b01, 32'h42, 1'b1});
        run(0, 1'b0, 32'h1000, 32'h0, 1, lat);
        check("t1_rd_lat", 64'(lat), 64'd3);
        idle(1);

        // P1 read of an unmapped address
        e0 = rd_en1;
        q1.push_back('{2'b10, 32'h0, 1'b0});
        run(1, 1'b0, 32'h2000, 32'h0, 1, lat);
        idle(1);
        check("t2_rd_en_pulses", 64'(rd_en1 - e0), 64'd1);

        // Tie from reset: P0 first, then P1
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        q1.push_back('{2'b01, 32'h0, 1'b1});
        q1.push_back('{2'b10, 32'h0, 1'b1});
        fork
            run(0, 1'b1, 32'h1000, 32'h10, 1, l0);
            run(1, 1'b1, 32'h1000, 32'h20, 1, l1);
        join
        check("t3_p0_lat", 64'(l0), 64'd3);
        check("t3_p1_lat", 64'(l1), 64'd7);
        idle(1);
        q1.push_back('{2'b10, 32'h21, 1'b1});
        run(1, 1'b0, 32'h1000, 32'h0, 1, lat);
        idle(1);
        q1.push_back('{2'b01, 32'h21, 1'b1});
        q1.push_back('{2'b10, 32'h0, 1'b1});
        fork
            run(0, 1'b0, 32'h1000, 32'h0, 1, l0);
            run(1, 1'b1, 32'h1000, 32'h30, 1, l1);
        join
        check("t3b_p0_lat", 64'(l0), 64'd3);
        idle(1);

        // P0 streams four reads; P1 joins after the first
        q1.push_back('{2'b01, 32'h31, 1'b1});
        q1.push_back('{2'b10, 32'h0, 1'b0});
        q1.push_back('{2'b01, 32'h31, 1'b1});
        q1.push_back('{2'b10, 32'h0, 1'b0});
        q1.push_back('{2'b01, 32'h31, 1'b1});
        q1.push_back('{2'b01, 32'h31, 1'b1});
        fork
            run(0, 1'b0, 32'h1000, 32'h0, 4, l0);
            begin
                hit = 1'b0;
                for (int i = 0; i < 64; i++) begin
                    @(negedge clk);
                    if (b1.rq_done[0]) begin
                        hit = 1'b1;
                        break;
                    end
                end
                if (!hit) check("t4_wait_timeout", 64'h0, 64'h1);
                run(1, 1'b0, 32'h2000, 32'h0, 2, l1);
            end
        join
        check("t4_p1_lat", 64'(l1), 64'd4);
        idle(1);

        // Reset while a P0 write waits for the target
        e0 = wr_en1;
        b1.rq_we[0] = 1'b1;
        b1.rq_addr[31:0] = 32'h1000;
        b1.rq_wdata[31:0] = 32'h55;
        b1.rq_wstrb[3:0] = 4'hF;
        b1.rq_valid[0] = 1'b1;
        idle(2);
        rst = 1'b1;
        #1;
        check("t5_ctl", 64'({b1.rq_done, b1.rq_okay, b1.reg_rd_en, b1.reg_wr_en}), 64'h0);
        check("t5_rdata", 64'(b1.rq_rdata), 64'h0);
        check("t5_bus", 64'(b1.reg_rd_addr | b1.reg_wr_addr | b1.reg_wr_data), 64'h0);
        check("t5_strb", 64'(b1.reg_wr_strb), 64'h0);
        check("t5_wr_issued", 64'(wr_en1 - e0), 64'd1);
        b1.rq_valid[0] = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(4);
        q1.push_back('{2'b01, 32'h0, 1'b1});
        run(0, 1'b1, 32'h1000, 32'h66, 1, lat);
        check("t5_next_lat", 64'(lat), 64'd3);
        idle(1);
        q1.push_back('{2'b01, 32'h67, 1'b1});
        run(0, 1'b0, 32'h1000, 32'h0, 1, lat);
        idle(1);

        // TGT_LAT=3 read
        e0 = rd_en3;
        q3.push_back('{2'b01, 32'h1, 1'b1});
        b3.rq_we[0] = 1'b0;
        b3.rq_addr[31:0] = 32'h1000;
        b3.rq_valid[0] = 1'b1;
        t0 = cyc;
        hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (b3.rq_done[0]) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("t6_timeout", 64'h0, 64'h1);
        check("t6_lat", 64'(cyc - t0), 64'd5);
        b3.rq_valid[0] = 1'b0;
        idle(2);
        check("t6_rd_en_pulses", 64'(rd_en3 - e0), 64'd1);
        check("t6_wr_en_pulses", 64'(wr_en3), 64'd0);

        idle(2);
        check("q1_left", 64'(q1.size()), 64'd0);
        check("q3_left", 64'(q3.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
